exc_vector_fetch: RTL and testbench

Exception-entry sequencer for the multicycle CPU. On an exception request it drives the memory address mux selector to the matching vector address (253/254/255), waits for the memory read, and loads the zero-extended handler byte into PC. It also saves EPC and the cause code. It sits between the main control FSM, which it stalls through `busy`, and the memory-address mux / PC write path, consuming the vectors that mux provides.

---
 rtl/exc_vector_fetch.sv | 134 +++++++++++++
 tb/tb_exc_vector_fetch.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_vector_fetch.sv
// Exception-entry sequencer: selects the handler vector, waits for memory, loads PC, saves EPC/cause.
// Optional build macro EXC_PENDING_EN adds sticky per-cause pending bits for requests seen while busy.
module exc_vector_fetch #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data,
  output logic [2:0]  mem_sel,
  output logic [31:0] pc_next,
  output logic        pc_load,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StWait, StLoad} state_e;

  localparam logic [2:0] WaitInit = 3'(MEM_WAIT - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] epc_q, epc_d;

  logic [2:0]  req;
  logic [2:0]  eff_req;
  logic [2:0]  acc_onehot;
  logic [1:0]  acc_code;
  logic        unused_mem_hi;

  // Bit 0 is the highest priority cause (opcode), bit 2 the lowest (div0).
  assign req = {exc_div0, exc_overflow, exc_opcode};

`ifdef EXC_PENDING_EN
  logic [2:0] pend_q, pend_d;

  assign eff_req = req | pend_q;

  always_comb begin
    pend_d = pend_q;
    if (state_q != StIdle) begin
      pend_d = pend_q | req;
    end else begin
      pend_d = pend_q & ~acc_onehot;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end
`else
  assign eff_req = req;
`endif

  // Isolate the lowest set bit, which is the winning request.
  assign acc_onehot = eff_req & (~eff_req + 3'd1);

  always_comb begin
    acc_code = 2'b00;
    if (acc_onehot[0]) begin
      acc_code = 2'b01;
    end else if (acc_onehot[1]) begin
      acc_code = 2'b10;
    end else if (acc_onehot[2]) begin
      acc_code = 2'b11;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    mem_sel = 3'b000;
    busy    = 1'b0;
    pc_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (acc_code != 2'b00) begin
          state_d = StWait;
          cnt_d   = WaitInit;
          cause_d = acc_code;
          epc_d   = pc_in - 32'd4;
        end
      end
      StWait: begin
        busy = 1'b1;
        // The latched cause doubles as the vector select: 01->100, 10->101, 11->110.
        mem_sel = {1'b1, cause_q - 2'd1};
        if (cnt_q == 3'd0) begin
          state_d = StLoad;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StLoad: begin
        busy    = 1'b1;
        mem_sel = {1'b1, cause_q - 2'd1};
        pc_load = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  assign pc_next       = pc_load ? {24'b0, mem_data[7:0]} : 32'd0;
  assign epc           = epc_q;
  assign cause         = cause_q;
  assign unused_mem_hi = ^mem_data[31:8];

endmodule

// File: tb/tb_exc_vector_fetch.sv
// Directed bench for exc_vector_fetch: scoreboard of expected PC loads plus per-cycle checks.
module tb_exc_vector_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_opcode, exc_overflow, exc_div0;
  logic [31:0] pc_in, mem_data;
  logic [2:0]  mem_sel;
  logic [31:0] pc_next, epc;
  logic        pc_load, busy;
  logic [1:0]  cause;

  logic        opc2;
  logic [31:0] pc_in2, mem_data2;
  logic [2:0]  mem_sel2;
  logic [31:0] pc_next2, epc2;
  logic        pc_load2, busy2;
  logic [1:0]  cause2;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] Mem253 = 32'hFFFF_FF40;
  localparam logic [31:0] Mem254 = 32'h0000_008C;
  localparam logic [31:0] Mem255 = 32'h1234_56A8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [1:0]  cause;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_lookup(input logic [2:0] sel);
    case (sel)
      3'b100:  return Mem253;
      3'b101:  return Mem254;
      3'b110:  return Mem255;
      default: return 32'h0BAD_0000;
    endcase
  endfunction

  assign mem_data  = mem_lookup(mem_sel);
  assign mem_data2 = mem_lookup(mem_sel2);

  exc_vector_fetch #(.MEM_WAIT(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .exc_opcode   (exc_opcode),
    .exc_overflow (exc_overflow),
    .exc_div0     (exc_div0),
    .pc_in        (pc_in),
    .mem_data     (mem_data),
    .mem_sel      (mem_sel),
    .pc_next      (pc_next),
    .pc_load      (pc_load),
    .epc          (epc),
    .cause        (cause),
    .busy         (busy)
  );

  exc_vector_fetch #(.MEM_WAIT(1)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .exc_opcode   (opc2),
    .exc_overflow (1'b0),
    .exc_div0     (1'b0),
    .pc_in        (pc_in2),
    .mem_data     (mem_data2),
    .mem_sel      (mem_sel2),
    .pc_next      (pc_next2),
    .pc_load      (pc_load2),
    .epc          (epc2),
    .cause        (cause2),
    .busy         (busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic exp_t mk_exp(input logic [31:0] vec, input logic [31:0] pc,
                                  input logic [1:0] c);
    exp_t e;
    e.pc    = vec & 32'h0000_00FF;
    e.epc   = pc - 32'd4;
    e.cause = c;
    return e;
  endfunction

  // Scoreboard: every PC load must match the oldest outstanding expected entry.
  always @(negedge clk) begin
    if (pc_load === 1'b1) begin
      checks++;
      assert (sbq.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected_pc_load observed=1 expected=0");
      end
      if (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_pc_next", pc_next, e.pc);
        chk("sb_epc", epc, e.epc);
        chk("sb_cause", {30'd0, cause}, {30'd0, e.cause});
      end
    end
  end

  initial begin
    reset = 1'b1;
    exc_opcode = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0;
    pc_in = 32'd0; opc2 = 1'b0; pc_in2 = 32'd0;
    tick(); tick();
    chk("rst_mem_sel", {29'd0, mem_sel}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pc_load", {31'd0, pc_load}, 32'd0);
    chk("rst_pc_next", pc_next, 32'd0);
    chk("rst_epc", epc, 32'd0);
    chk("rst_cause", {30'd0, cause}, 32'd0);
    reset = 1'b0;
    tick();

    // Overflow entry
    pc_in = 32'h10; exc_overflow = 1'b1;
    sbq.push_back(mk_exp(Mem254, pc_in, 2'b10));
    tick();  // T+1
    exc_overflow = 1'b0;
    chk("ovf_t1_sel", {29'd0, mem_sel}, 32'b101);
    chk("ovf_t1_busy", {31'd0, busy}, 32'd1);
    chk("ovf_t1_load", {31'd0, pc_load}, 32'd0);
    chk("ovf_t1_epc", epc, 32'h0000_000C);
    chk("ovf_t1_cause", {30'd0, cause}, 32'b10);
    tick();  // T+2
    chk("ovf_t2_sel", {29'd0, mem_sel}, 32'b101);
    chk("ovf_t2_load", {31'd0, pc_load}, 32'd0);
    tick();  // T+3
    chk("ovf_t3_sel", {29'd0, mem_sel}, 32'b101);
    chk("ovf_t3_load", {31'd0, pc_load}, 32'd1);
    chk("ovf_t3_pc_next", pc_next, 32'h0000_008C);
    tick();  // T+4
    chk("ovf_t4_busy", {31'd0, busy}, 32'd0);
    chk("ovf_t4_sel", {29'd0, mem_sel}, 32'd0);
    chk("ovf_t4_load", {31'd0, pc_load}, 32'd0);
    chk("ovf_t4_epc_held", epc, 32'h0000_000C);
    chk("ovf_t4_cause_held", {30'd0, cause}, 32'b10);

    // Simultaneous opcode + div0: opcode wins, upper memory bits masked
    pc_in = 32'h100; exc_opcode = 1'b1; exc_div0 = 1'b1;
    sbq.push_back(mk_exp(Mem253, pc_in, 2'b01));
    tick();
    exc_opcode = 1'b0; exc_div0 = 1'b0;
    chk("sim_cause", {30'd0, cause}, 32'b01);
    chk("sim_sel", {29'd0, mem_sel}, 32'b100);
    tick(); tick();
    chk("sim_pc_next", pc_next, 32'h0000_0040);
    tick();
    chk("sim_idle", {31'd0, busy}, 32'd0);

    // EPC wrap
    pc_in = 32'd0; exc_div0 = 1'b1;
    sbq.push_back(mk_exp(Mem255, pc_in, 2'b11));
    tick();
    exc_div0 = 1'b0;
    chk("wrap_epc", epc, 32'hFFFF_FFFC);
    chk("wrap_cause", {30'd0, cause}, 32'b11);
    chk("wrap_sel", {29'd0, mem_sel}, 32'b110);
    tick(); tick(); tick();
    chk("wrap_idle", {31'd0, busy}, 32'd0);

    // Request during busy
    pc_in = 32'h200; exc_overflow = 1'b1;
    sbq.push_back(mk_exp(Mem254, pc_in, 2'b10));
    tick();  // T+1
    exc_overflow = 1'b0;
    tick();  // T+2
    exc_div0 = 1'b1;
`ifdef EXC_PENDING_EN
    sbq.push_back(mk_exp(Mem255, pc_in, 2'b11));
`endif
    tick();  // T+3
    exc_div0 = 1'b0;
    chk("bsy_t3_load", {31'd0, pc_load}, 32'd1);
    tick();  // T+4
    chk("bsy_t4_busy", {31'd0, busy}, 32'd0);
`ifdef EXC_PENDING_EN
    for (int i = 5; i <= 7; i++) begin
      tick();
      chk("bsy_pend_sel", {29'd0, mem_sel}, 32'b110);
      chk("bsy_pend_cause", {30'd0, cause}, 32'b11);
    end
    tick();
    chk("bsy_pend_idle", {31'd0, busy}, 32'd0);
`else
    for (int i = 5; i <= 7; i++) begin
      tick();
      chk("bsy_ignored_busy", {31'd0, busy}, 32'd0);
      chk("bsy_ignored_sel", {29'd0, mem_sel}, 32'd0);
    end
`endif

    // Reset asserted asynchronously mid-WAIT
    pc_in = 32'h300; exc_overflow = 1'b1;
    tick();  // T+1
    exc_overflow = 1'b0;
    chk("rstw_busy_before", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rstw_busy", {31'd0, busy}, 32'd0);
    chk("rstw_sel", {29'd0, mem_sel}, 32'd0);
    chk("rstw_load", {31'd0, pc_load}, 32'd0);
    chk("rstw_pc_next", pc_next, 32'd0);
    chk("rstw_epc", epc, 32'd0);
    chk("rstw_cause", {30'd0, cause}, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rstw_no_load", {31'd0, pc_load}, 32'd0);
      chk("rstw_idle", {31'd0, busy}, 32'd0);
    end

    // MEM_WAIT = 1 instance
    pc_in2 = 32'h44; opc2 = 1'b1;
    tick();  // T+1
    opc2 = 1'b0;
    chk("mw1_t1_busy", {31'd0, busy2}, 32'd1);
    chk("mw1_t1_load", {31'd0, pc_load2}, 32'd0);
    chk("mw1_t1_sel", {29'd0, mem_sel2}, 32'b100);
    tick();  // T+2
    chk("mw1_t2_load", {31'd0, pc_load2}, 32'd1);
    chk("mw1_t2_pc_next", pc_next2, 32'h0000_0040);
    chk("mw1_t2_epc", epc2, 32'h0000_0040);
    tick();  // T+3
    chk("mw1_t3_busy", {31'd0, busy2}, 32'd0);
    chk("mw1_t3_load", {31'd0, pc_load2}, 32'd0);

    tick(); tick();
    chk("sb_drained", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
